// File: rtl/net_packet_rx_pkg.sv
// Shared network-ingress definitions: packet layout, op codes, core state and rx FSM states.
package net_packet_rx_pkg;

  localparam int unsigned ID_LENGTH       = 10;
  localparam int unsigned IMEM_ADDR_WIDTH = 10;
  localparam int unsigned RD_SIZE         = 5;
  localparam int unsigned MASK_LENGTH     = 3;
  localparam int unsigned NET_ADDR_W      = 10;
  localparam int unsigned NET_DATA_W      = 32;

  typedef enum logic [2:0] {
    NULL  = 3'b000,
    INSTR = 3'b001,
    REG   = 3'b010,
    PC    = 3'b011,
    BAR   = 3'b100
  } net_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    ERR  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ISSUE,
    RX_PC_WAIT
  } rx_state_e;

  typedef struct packed {
    net_op_e                 net_op;
    logic [ID_LENGTH-1:0]    id;
    logic [NET_ADDR_W-1:0]   net_addr;
    logic [NET_DATA_W-1:0]   net_data;
  } net_packet_s;

  localparam logic [ID_LENGTH-1:0] BCAST_ID = '1;

  function automatic logic id_match(input logic [ID_LENGTH-1:0] id,
                                    input logic [ID_LENGTH-1:0] core_id);
    return (id == core_id) || (id == BCAST_ID);
  endfunction

endpackage

// File: rtl/net_rx_fifo.sv
// Synchronous packet FIFO; extra pointer MSB distinguishes full from empty.
module net_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/net_packet_rx.sv
// Network ingress: filters packets by core ID, buffers them and dispatches
// INSTR/REG/PC/BAR ops in order as write strobes, with drop and error accounting.
module net_packet_rx
  import net_packet_rx_pkg::*;
#(
  parameter int unsigned ID_W       = ID_LENGTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMEM_AW    = IMEM_ADDR_WIDTH,
  parameter int unsigned RF_AW      = RD_SIZE,
  parameter int unsigned MASK_W     = MASK_LENGTH,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ID_W-1:0]                core_id_i,
  input  logic                           net_v_i,
  input  logic [$bits(net_packet_s)-1:0] net_packet_i,
  output logic                           net_ready_o,
  input  logic [1:0]                     core_state_i,
  output logic                           imem_wen_o,
  output logic [IMEM_AW-1:0]             imem_addr_o,
  output logic [15:0]                    imem_data_o,
  output logic                           rf_req_o,
  input  logic                           rf_gnt_i,
  output logic [RF_AW-1:0]               rf_addr_o,
  output logic [31:0]                    rf_data_o,
  output logic                           pc_wen_o,
  output logic [IMEM_AW-1:0]             pc_o,
  output logic                           bar_wen_o,
  output logic [MASK_W-1:0]              bar_mask_o,
  output logic [CNT_W-1:0]               drop_cnt_o,
  output logic [CNT_W-1:0]               err_cnt_o,
  output logic                           err_o
);

  net_packet_s pkt_in, head;
  logic        accept, push, drop;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic        core_idle, err_inc;
  rx_state_e   state_q, state_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;
  logic        err_q, err_d;
  logic        unused_head;

  assign pkt_in = net_packet_s'(net_packet_i);

  // Filtered packets are counted but never occupy a FIFO slot.
  assign accept = net_v_i & net_ready_o;
  assign push   = accept & id_match(pkt_in.id, core_id_i) & (pkt_in.net_op != NULL);
  assign drop   = accept & ~push;

  assign net_ready_o = ~fifo_full;
  assign core_idle   = (core_state_i == IDLE);

  net_rx_fifo #(
    .WIDTH ($bits(net_packet_s)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (pkt_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // RX_IDLE issues the head directly so single-cycle ops sustain one per cycle;
  // RX_ISSUE holds a REG request, RX_PC_WAIT holds a PC load until the core idles.
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    imem_wen_o = 1'b0;
    rf_req_o   = 1'b0;
    pc_wen_o   = 1'b0;
    bar_wen_o  = 1'b0;
    err_inc    = 1'b0;
    if (!fifo_empty) begin
      if (state_q == RX_PC_WAIT) begin
        pc_wen_o = core_idle;
        fifo_pop = core_idle;
      end else begin
        case (head.net_op)
          INSTR: begin
            imem_wen_o = 1'b1;
            fifo_pop   = 1'b1;
          end
          REG: begin
            rf_req_o = 1'b1;
            fifo_pop = rf_gnt_i;
          end
          PC: begin
            pc_wen_o = core_idle;
            fifo_pop = core_idle;
          end
          BAR: begin
            bar_wen_o = 1'b1;
            fifo_pop  = 1'b1;
          end
          NULL:    fifo_pop = 1'b1;
          default: begin
            fifo_pop = 1'b1;
            err_inc  = 1'b1;
          end
        endcase
      end
    end
    if (fifo_empty || fifo_pop)   state_d = RX_IDLE;
    else if (head.net_op == PC)   state_d = RX_PC_WAIT;
    else                          state_d = RX_ISSUE;
  end

  // Data outputs are gated by their strobe so they read 0 whenever idle.
  assign imem_addr_o = imem_wen_o ? head.net_addr[IMEM_AW-1:0] : '0;
  assign imem_data_o = imem_wen_o ? head.net_data[15:0]        : '0;
  assign rf_addr_o   = rf_req_o   ? head.net_addr[RF_AW-1:0]   : '0;
  assign rf_data_o   = rf_req_o   ? head.net_data              : '0;
  assign pc_o        = pc_wen_o   ? head.net_addr[IMEM_AW-1:0] : '0;
  assign bar_mask_o  = bar_wen_o  ? head.net_data[MASK_W-1:0]  : '0;

  assign unused_head = ^{head.id, head.net_addr};

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_d      = err_q | err_inc;
    if (drop && (drop_cnt_q != '1))   drop_cnt_d = drop_cnt_q + CNT_W'(1);
    if (err_inc && (err_cnt_q != '1)) err_cnt_d  = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_q      <= err_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign err_cnt_o  = err_cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_net_packet_rx.sv
// Bench for net_packet_rx: constant vector table, directed corner sequences and a
// randomized run checked every cycle against a queue-based reference model.
module tb_net_packet_rx;
  import net_packet_rx_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int          SAT   = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  core_id_i = 10'd5;
  logic        net_v_i = 1'b0;
  net_packet_s net_packet_i = '0;
  logic        net_ready_o;
  logic [1:0]  core_state_i = 2'b00;
  logic        imem_wen_o;
  logic [9:0]  imem_addr_o;
  logic [15:0] imem_data_o;
  logic        rf_req_o;
  logic        rf_gnt_i = 1'b0;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic        pc_wen_o;
  logic [9:0]  pc_o;
  logic        bar_wen_o;
  logic [2:0]  bar_mask_o;
  logic [15:0] drop_cnt_o, err_cnt_o;
  logic        err_o;

  net_packet_rx dut (
    .clk          (clk),
    .reset        (reset),
    .core_id_i    (core_id_i),
    .net_v_i      (net_v_i),
    .net_packet_i (net_packet_i),
    .net_ready_o  (net_ready_o),
    .core_state_i (core_state_i),
    .imem_wen_o   (imem_wen_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .rf_req_o     (rf_req_o),
    .rf_gnt_i     (rf_gnt_i),
    .rf_addr_o    (rf_addr_o),
    .rf_data_o    (rf_data_o),
    .pc_wen_o     (pc_wen_o),
    .pc_o         (pc_o),
    .bar_wen_o    (bar_wen_o),
    .bar_mask_o   (bar_mask_o),
    .drop_cnt_o   (drop_cnt_o),
    .err_cnt_o    (err_cnt_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: accepted packets in arrival order plus counters.
  net_packet_s mq[$];
  int          m_drop = 0;
  int          m_err  = 0;
  logic        m_errf = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic [9:0]  id;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  e_strb;  // {imem, rf, pc, bar}
    logic [31:0] e_a;
    logic [31:0] e_d;
    int          e_drop;
    int          e_err;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic net_packet_s mk(input logic [2:0] op, input logic [9:0] id,
                                     input logic [9:0] a, input logic [31:0] d);
    net_packet_s p;
    p.net_op   = net_op_e'(op);
    p.id       = id;
    p.net_addr = a;
    p.net_data = d;
    return p;
  endfunction

  function automatic logic [3:0] strobes();
    return {imem_wen_o, rf_req_o, pc_wen_o, bar_wen_o};
  endfunction

  // Compare this cycle's outputs with the model, then advance the model across the edge.
  task automatic model_step();
    logic [3:0]  e_strb;
    logic        e_pop, e_err, e_ready;
    net_packet_s h;
    e_strb  = 4'b0000;
    e_pop   = 1'b0;
    e_err   = 1'b0;
    e_ready = (mq.size() < DEPTH);
    h       = '0;
    if (mq.size() != 0) begin
      h = mq[0];
      if (h.net_op == INSTR) begin
        e_strb = 4'b1000; e_pop = 1'b1;
      end else if (h.net_op == REG) begin
        e_strb = 4'b0100; e_pop = rf_gnt_i;
      end else if (h.net_op == PC) begin
        if (core_state_i == IDLE) begin
          e_strb = 4'b0010; e_pop = 1'b1;
        end
      end else if (h.net_op == BAR) begin
        e_strb = 4'b0001; e_pop = 1'b1;
      end else begin
        e_pop = 1'b1; e_err = 1'b1;
      end
    end
    chk("m_ready", net_ready_o, e_ready);
    chk("m_strobes", strobes(), e_strb);
    if (e_strb[3]) begin
      chk("m_imem_addr", imem_addr_o, h.net_addr);
      chk("m_imem_data", imem_data_o, h.net_data[15:0]);
    end
    if (e_strb[2]) begin
      chk("m_rf_addr", rf_addr_o, h.net_addr[4:0]);
      chk("m_rf_data", rf_data_o, h.net_data);
    end
    if (e_strb[1]) chk("m_pc", pc_o, h.net_addr);
    if (e_strb[0]) chk("m_bar_mask", bar_mask_o, h.net_data[2:0]);
    chk("m_drop_cnt", drop_cnt_o, m_drop);
    chk("m_err_cnt", err_cnt_o, m_err);
    chk("m_err", err_o, m_errf);
    if (e_pop) void'(mq.pop_front());
    if (net_v_i && e_ready) begin
      if ((net_packet_i.id == core_id_i || net_packet_i.id == 10'h3FF) &&
          net_packet_i.net_op != NULL) mq.push_back(net_packet_i);
      else if (m_drop < SAT) m_drop++;
    end
    if (e_err) begin
      if (m_err < SAT) m_err++;
      m_errf = 1'b1;
    end
  endtask

  task automatic cycle(input logic v, input net_packet_s p, input logic [1:0] cs,
                       input logic g);
    @(negedge clk);
    net_v_i      = v;
    net_packet_i = p;
    core_state_i = cs;
    rf_gnt_i     = g;
    #2 model_step();
  endtask

  task automatic idle(input logic [1:0] cs, input logic g);
    cycle(1'b0, '0, cs, g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    net_v_i      = 1'b0;
    rf_gnt_i     = 1'b0;
    core_state_i = IDLE;
    reset        = 1'b1;
    #1;
    chk("rst_ready", net_ready_o, 1);
    chk("rst_strobes", strobes(), 0);
    chk("rst_data", |{imem_addr_o, imem_data_o, rf_addr_o, rf_data_o, pc_o, bar_mask_o}, 0);
    chk("rst_counts", {drop_cnt_o, err_cnt_o}, 0);
    chk("rst_err", err_o, 0);
    mq.delete();
    m_drop = 0;
    m_err  = 0;
    m_errf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [9:0] rand_id();
    case ($urandom_range(0, 3))
      0:       return 10'h3FF;
      1:       return 10'h013;
      default: return core_id_i;
    endcase
  endfunction

  initial begin
    tbl[0]  = '{3'b001, 10'd5,   10'h012, 32'h0000A5C3, 4'b1000, 32'h012, 32'hA5C3,     0, 0};
    tbl[1]  = '{3'b010, 10'd5,   10'h007, 32'hDEADBEEF, 4'b0100, 32'h007, 32'hDEADBEEF, 0, 0};
    tbl[2]  = '{3'b011, 10'd5,   10'h100, 32'h00000000, 4'b0010, 32'h100, 32'h0,        0, 0};
    tbl[3]  = '{3'b100, 10'd5,   10'h000, 32'hFFFFFFF5, 4'b0001, 32'h0,   32'h5,        0, 0};
    tbl[4]  = '{3'b001, 10'h3FF, 10'h3AB, 32'h12345678, 4'b1000, 32'h3AB, 32'h5678,     0, 0};
    tbl[5]  = '{3'b001, 10'd3,   10'h055, 32'h00000001, 4'b0000, 32'h0,   32'h0,        1, 0};
    tbl[6]  = '{3'b000, 10'd5,   10'h055, 32'h00000001, 4'b0000, 32'h0,   32'h0,        1, 0};
    tbl[7]  = '{3'b110, 10'd5,   10'h000, 32'h00000000, 4'b0000, 32'h0,   32'h0,        0, 1};
    tbl[8]  = '{3'b010, 10'd5,   10'h3E7, 32'h0BADF00D, 4'b0100, 32'h007, 32'h0BADF00D, 0, 0};
    tbl[9]  = '{3'b101, 10'h3FF, 10'h001, 32'h00000007, 4'b0000, 32'h0,   32'h0,        0, 1};
    tbl[10] = '{3'b111, 10'd5,   10'h002, 32'h00000003, 4'b0000, 32'h0,   32'h0,        0, 1};

    #1 reset = 1'b1;
    do_reset();

    // Single packets: nothing in the accept cycle, one strobe the next cycle, then quiet.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      cycle(1'b1, mk(tbl[i].op, tbl[i].id, tbl[i].addr, tbl[i].data), IDLE, 1'b1);
      chk($sformatf("tbl%0d_nobypass", i), strobes(), 0);
      idle(IDLE, 1'b1);
      chk($sformatf("tbl%0d_strobe", i), strobes(), tbl[i].e_strb);
      case (tbl[i].e_strb)
        4'b1000: begin
          chk($sformatf("tbl%0d_imem_addr", i), imem_addr_o, tbl[i].e_a);
          chk($sformatf("tbl%0d_imem_data", i), imem_data_o, tbl[i].e_d);
        end
        4'b0100: begin
          chk($sformatf("tbl%0d_rf_addr", i), rf_addr_o, tbl[i].e_a);
          chk($sformatf("tbl%0d_rf_data", i), rf_data_o, tbl[i].e_d);
        end
        4'b0010: chk($sformatf("tbl%0d_pc", i), pc_o, tbl[i].e_a);
        4'b0001: chk($sformatf("tbl%0d_bar", i), bar_mask_o, tbl[i].e_d);
        default: ;
      endcase
      idle(IDLE, 1'b1);
      chk($sformatf("tbl%0d_one_cycle", i), strobes(), 0);
      chk($sformatf("tbl%0d_drop_cnt", i), drop_cnt_o, tbl[i].e_drop);
      chk($sformatf("tbl%0d_err_cnt", i), err_cnt_o, tbl[i].e_err);
      chk($sformatf("tbl%0d_err", i), err_o, tbl[i].e_err != 0);
    end

    // REG held through three cycles without grant; following INSTR waits behind it.
    do_reset();
    cycle(1'b1, mk(REG, 10'd5, 10'h007, 32'hDEADBEEF), IDLE, 1'b0);
    cycle(1'b1, mk(INSTR, 10'd5, 10'h021, 32'h00000077), IDLE, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) idle(IDLE, 1'b0);
      chk("reg_hold_req", rf_req_o, 1);
      chk("reg_hold_addr", rf_addr_o, 5'd7);
      chk("reg_hold_data", rf_data_o, 32'hDEADBEEF);
      chk("reg_blocks_instr", imem_wen_o, 0);
    end
    idle(IDLE, 1'b1);
    chk("reg_grant_req", rf_req_o, 1);
    chk("reg_grant_data", rf_data_o, 32'hDEADBEEF);
    idle(IDLE, 1'b0);
    chk("reg_released", rf_req_o, 0);
    chk("reg_next_instr", {imem_wen_o, imem_addr_o}, {1'b1, 10'h021});

    // PC waits for an idle core; a BAR queued behind it follows one cycle later.
    do_reset();
    cycle(1'b1, mk(PC, 10'd5, 10'h100, 32'h0), RUN, 1'b0);
    cycle(1'b1, mk(BAR, 10'd5, 10'h000, 32'h00000006), RUN, 1'b0);
    for (int c = 2; c < 6; c++) begin
      idle(RUN, 1'b0);
      chk("pc_wait_strobes", strobes(), 0);
    end
    idle(IDLE, 1'b0);
    chk("pc_issue", {pc_wen_o, pc_o}, {1'b1, 10'h100});
    chk("pc_bar_held", bar_wen_o, 0);
    idle(RUN, 1'b0);
    chk("pc_then_bar", {bar_wen_o, bar_mask_o}, {1'b1, 3'd6});
    chk("pc_once", pc_wen_o, 0);

    // Fill behind a stalled REG, refuse a fifth packet until after the first pop.
    do_reset();
    cycle(1'b1, mk(REG, 10'd5, 10'h001, 32'h11111111), IDLE, 1'b0);
    cycle(1'b1, mk(INSTR, 10'd5, 10'h0A1, 32'h0000AAA1), IDLE, 1'b0);
    cycle(1'b1, mk(INSTR, 10'd5, 10'h0A2, 32'h0000AAA2), IDLE, 1'b0);
    cycle(1'b1, mk(INSTR, 10'd5, 10'h0A3, 32'h0000AAA3), IDLE, 1'b0);
    cycle(1'b1, mk(INSTR, 10'd5, 10'h0A5, 32'h0000AAA5), IDLE, 1'b0);
    chk("full_not_ready", net_ready_o, 0);
    cycle(1'b1, mk(INSTR, 10'd5, 10'h0A5, 32'h0000AAA5), IDLE, 1'b1);
    chk("full_pop_not_ready", net_ready_o, 0);
    cycle(1'b1, mk(INSTR, 10'd5, 10'h0A5, 32'h0000AAA5), IDLE, 1'b0);
    chk("after_pop_ready", net_ready_o, 1);
    chk("after_pop_first", imem_addr_o, 10'h0A1);
    idle(IDLE, 1'b0);
    idle(IDLE, 1'b0);
    idle(IDLE, 1'b0);
    chk("fifth_dispatched", {imem_wen_o, imem_addr_o}, {1'b1, 10'h0A5});
    idle(IDLE, 1'b0);
    chk("fifth_only_once", imem_wen_o, 0);

    // Foreign ID and NULL dropped, broadcast dispatched.
    do_reset();
    cycle(1'b1, mk(INSTR, 10'd3, 10'h033, 32'h00003333), IDLE, 1'b0);
    cycle(1'b1, mk(INSTR, 10'h3FF, 10'h0BC, 32'h0000BCBC), IDLE, 1'b0);
    chk("drop_foreign_nostrobe", strobes(), 0);
    cycle(1'b1, mk(NULL, 10'd5, 10'h044, 32'h00004444), IDLE, 1'b0);
    chk("bcast_dispatch", {imem_wen_o, imem_addr_o, imem_data_o}, {1'b1, 10'h0BC, 16'hBCBC});
    idle(IDLE, 1'b0);
    chk("drop_cnt_two", drop_cnt_o, 2);
    chk("drop_null_nostrobe", strobes(), 0);

    // Undefined op sets the error state; reset during a REG stall clears everything.
    do_reset();
    cycle(1'b1, mk(3'b110, 10'd5, 10'h000, 32'h0), IDLE, 1'b0);
    cycle(1'b1, mk(REG, 10'd5, 10'h00C, 32'hCAFEF00D), IDLE, 1'b0);
    chk("undef_nostrobe", strobes(), 0);
    idle(IDLE, 1'b0);
    chk("undef_err_cnt", err_cnt_o, 1);
    chk("undef_err", err_o, 1);
    chk("stall_req", rf_req_o, 1);
    idle(IDLE, 1'b0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle(IDLE, 1'b1);
      chk("post_reset_no_reissue", strobes(), 0);
      chk("post_reset_err_clear", {err_o, err_cnt_o}, 0);
    end

    // Randomized traffic against the model.
    do_reset();
    core_id_i = 10'h02A;
    for (int k = 0; k < 1500; k++) begin
      cycle($urandom_range(0, 3) != 0,
            mk(3'($urandom_range(0, 7)), rand_id(), 10'($urandom), $urandom),
            2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
